// File: rtl/xpb_lookup_sequencer_if.sv
// Operand request, XPB table lookup and result handshake bundle for the lookup sequencer.
interface xpb_lookup_sequencer_if #(
    parameter int NUM_CHUNKS = 8,
    parameter int CHUNK_W    = 5,
    parameter int XPB_W      = 1024
);
    localparam int SEL_W = $clog2(NUM_CHUNKS);
    localparam int ACC_W = XPB_W + $clog2(NUM_CHUNKS);

    logic                          start_valid;
    logic                          start_ready;
    logic [NUM_CHUNKS*CHUNK_W-1:0] chunks_in;
    logic                          xpb_issue;
    logic [SEL_W-1:0]              xpb_sel;
    logic [CHUNK_W-1:0]            xpb_idx;
    logic [XPB_W-1:0]              xpb_data;
    logic                          result_valid;
    logic                          result_ready;
    logic [ACC_W-1:0]              result;

    modport slave (
        input  start_valid, chunks_in, xpb_data, result_ready,
        output start_ready, xpb_issue, xpb_sel, xpb_idx, result_valid, result
    );

    modport master (
        output start_valid, chunks_in, xpb_data, result_ready,
        input  start_ready, xpb_issue, xpb_sel, xpb_idx, result_valid, result
    );
endinterface

// File: rtl/xpb_lookup_sequencer.sv
// Splits one operand into index chunks, issues one XPB table lookup per cycle and sums the returns.
//   state    | meaning
//   ST_IDLE  | ready for an operand
//   ST_ISSUE | one lookup per cycle, chunk r_cnt
//   ST_DRAIN | fold in the final lookup that is still in flight
//   ST_DONE  | hold the sum until the consumer takes it
module xpb_lookup_sequencer #(
    parameter int NUM_CHUNKS = 8,
    parameter int CHUNK_W    = 5,
    parameter int XPB_W      = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    xpb_lookup_sequencer_if.slave   bus
);
    localparam int SEL_W = $clog2(NUM_CHUNKS);
    localparam int ACC_W = XPB_W + $clog2(NUM_CHUNKS);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

    state_t                               r_state;
    state_t                               w_state_nxt;
    logic [SEL_W-1:0]                     r_cnt;
    logic [SEL_W-1:0]                     w_cnt_inc;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]   r_chunks;
    logic [CHUNK_W-1:0]                   r_idx;
    logic                                 r_pv;
    logic [ACC_W-1:0]                     r_acc;
    logic                                 w_accept;
    logic                                 w_last;

    assign w_accept  = (r_state == ST_IDLE) && bus.start_valid;
    assign w_last    = (r_cnt == SEL_W'(NUM_CHUNKS - 1));
    assign w_cnt_inc = r_cnt + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        bus.start_ready  = 1'b0;
        bus.xpb_issue    = 1'b0;
        bus.result_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.start_ready = 1'b1;
                if (bus.start_valid) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.xpb_issue = 1'b1;
                if (w_last) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                bus.result_valid = 1'b1;
                if (bus.result_ready) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // r_cnt stops at the last chunk so xpb_sel/xpb_idx hold their final lookup while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_chunks <= '0;
            r_idx    <= '0;
            r_pv     <= 1'b0;
            r_acc    <= '0;
        end else begin
            if (w_accept) begin
                r_chunks <= bus.chunks_in;
                r_cnt    <= '0;
                r_idx    <= bus.chunks_in[CHUNK_W-1:0];
                r_acc    <= '0;
            end else if (r_pv) begin
                r_acc <= r_acc + ACC_W'(bus.xpb_data);
            end

            if (r_state == ST_ISSUE) begin
                r_pv <= 1'b1;
                if (!w_last) begin
                    r_cnt <= w_cnt_inc;
                    r_idx <= r_chunks[w_cnt_inc];
                end
            end else if (r_state == ST_DRAIN) begin
                r_pv <= 1'b0;
            end
        end
    end

    assign bus.xpb_sel = r_cnt;
    assign bus.xpb_idx = r_idx;
    assign bus.result  = r_acc;

endmodule

// File: tb/tb_xpb_lookup_sequencer.sv
// Directed bench for xpb_lookup_sequencer with a registered table model (idx==0 -> 0, else sel*32+idx).
module tb_xpb_lookup_sequencer;
    localparam int NC = 8;
    localparam int CW = 5;
    localparam int XW = 1024;
    localparam int SW = 3;
    localparam int AW = 1027;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ovf = 1'b0;

    always #5 clk = ~clk;

    xpb_lookup_sequencer_if #(.NUM_CHUNKS(NC), .CHUNK_W(CW), .XPB_W(XW)) bus ();

    xpb_lookup_sequencer #(.NUM_CHUNKS(NC), .CHUNK_W(CW), .XPB_W(XW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always_ff @(posedge clk) begin
        if (bus.xpb_issue) begin
            if (ovf) bus.xpb_data <= '1;
            else if (bus.xpb_idx == '0) bus.xpb_data <= '0;
            else bus.xpb_data <= XW'({bus.xpb_sel, bus.xpb_idx});
        end
    end

    // Issue log, cleared whenever an operand is about to be accepted or reset is asserted.
    int          cyc = 0;
    int          issue_cnt = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    int          rv_rises = 0;
    logic        prev_rv = 1'b0;
    logic [23:0] sel_pack = '0;
    logic [39:0] idx_pack = '0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n || (bus.start_valid && bus.start_ready)) begin
            issue_cnt = 0;
            rv_rises  = 0;
            sel_pack  = '0;
            idx_pack  = '0;
        end else begin
            if (bus.xpb_issue) begin
                if (issue_cnt < NC) begin
                    sel_pack[issue_cnt*SW +: SW] = bus.xpb_sel;
                    idx_pack[issue_cnt*CW +: CW] = bus.xpb_idx;
                end
                if (issue_cnt == 0) first_cyc = cyc;
                last_cyc  = cyc;
                issue_cnt = issue_cnt + 1;
            end
            if (bus.result_valid && !prev_rv) rv_rises = rv_rises + 1;
        end
        prev_rv = bus.result_valid;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [39:0] ch);
        check_val("start_ready_idle", AW'(bus.start_ready), AW'(1));
        bus.chunks_in   = ch;
        bus.start_valid = 1'b1;
        step();
        bus.start_valid = 1'b0;
        bus.chunks_in   = ~ch;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.result_valid && lat < 40) begin
            step();
            lat = lat + 1;
        end
    endtask

    int                lat;
    logic [AW-1:0]     r_res;
    logic [AW-1:0]     exp_ovf;

    initial begin
        bus.start_valid  = 1'b0;
        bus.chunks_in    = '0;
        bus.result_ready = 1'b1;
        exp_ovf = {{(AW-3){1'b1}}, 3'b000};

        #1;
        check_val("rst_start_ready", AW'(bus.start_ready), AW'(1));
        check_val("rst_issue", AW'(bus.xpb_issue), AW'(0));
        check_val("rst_sel", AW'(bus.xpb_sel), AW'(0));
        check_val("rst_idx", AW'(bus.xpb_idx), AW'(0));
        check_val("rst_rv", AW'(bus.result_valid), AW'(0));
        check_val("rst_result", bus.result, AW'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: all chunks 5'h1F
        start_op({8{5'h1F}});
        wait_result(lat);
        check_val("t1_latency", AW'(lat), AW'(9));
        check_val("t1_result", bus.result, AW'(12'h478));
        step();
        check_val("t1_rv_low", AW'(bus.result_valid), AW'(0));
        check_val("t1_issues", AW'(issue_cnt), AW'(8));
        check_val("t1_sel_seq", AW'(sel_pack), AW'(24'hFAC688));
        check_val("t1_consecutive", AW'(last_cyc - first_cyc), AW'(7));
        check_val("t1_sel_hold", AW'(bus.xpb_sel), AW'(7));

        // 2: all-zero operand
        start_op('0);
        wait_result(lat);
        check_val("t2_result", bus.result, AW'(0));
        step();
        step();
        check_val("t2_issues", AW'(issue_cnt), AW'(8));
        check_val("t2_rv_once", AW'(rv_rises), AW'(1));

        // 3: only chunk 3 = 2
        start_op(40'h00_0001_0000);
        wait_result(lat);
        check_val("t3_result", bus.result, AW'(8'h62));
        step();
        check_val("t3_idx_seq", AW'(idx_pack), AW'(40'h00_0001_0000));

        // 4: table returns all-ones
        ovf = 1'b1;
        start_op({8{5'h1F}});
        wait_result(lat);
        r_res = bus.result;
        check_val("t4_result_hi", AW'(r_res[AW-1:512]), AW'(exp_ovf[AW-1:512]));
        check_val("t4_result_lo", AW'(r_res[511:0]), AW'(exp_ovf[511:0]));
        step();
        ovf = 1'b0;

        // 5: backpressure on the result
        bus.result_ready = 1'b0;
        start_op(40'h08_0000_0005);
        wait_result(lat);
        check_val("t5_latency", AW'(lat), AW'(9));
        for (int k = 0; k < 5; k++) begin
            check_val("t5_rv_hold", AW'(bus.result_valid), AW'(1));
            check_val("t5_result_hold", bus.result, AW'(8'hE6));
            check_val("t5_start_ready", AW'(bus.start_ready), AW'(0));
            if (k == 2) begin
                bus.chunks_in   = {8{5'h1F}};
                bus.start_valid = 1'b1;
            end
            step();
            bus.start_valid = 1'b0;
        end
        bus.result_ready = 1'b1;
        step();
        check_val("t5_rv_done", AW'(bus.result_valid), AW'(0));
        check_val("t5_ready_back", AW'(bus.start_ready), AW'(1));
        step();
        step();
        check_val("t5_no_issue", AW'(bus.xpb_issue), AW'(0));
        check_val("t5_issues", AW'(issue_cnt), AW'(8));

        // 6: reset in the middle of a lookup sequence
        start_op({8{5'h1F}});
        repeat (4) step();
        check_val("t6_mid_sel", AW'(bus.xpb_sel), AW'(4));
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_rv", AW'(bus.result_valid), AW'(0));
        check_val("t6_rst_ready", AW'(bus.start_ready), AW'(1));
        check_val("t6_rst_issue", AW'(bus.xpb_issue), AW'(0));
        check_val("t6_rst_result", bus.result, AW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        start_op({8{5'h1F}});
        wait_result(lat);
        check_val("t6_latency", AW'(lat), AW'(9));
        check_val("t6_result", bus.result, AW'(12'h478));
        step();
        check_val("t6_rv_once", AW'(rv_rises), AW'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
